// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word-fall-through receive FIFO.
// A shared bit timer mid-samples each bit; good bytes are pushed, bad stop bits are reported.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 1667,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_unsafe,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_RECOVER
  } state_e;

  logic          rx_meta_q, rx_s_q;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_req, ferr_d, overrun_d;
  logic          frame_err_q, overrun_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          empty, full, pop, push;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx_unsafe;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (timer_q == HALF_T) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer_q == FULL_T) begin
          timer_d   = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (timer_q == FULL_T) begin
          timer_d = '0;
          if (rx_s_q) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_RECOVER;
          end
        end
      end
      S_RECOVER: begin
        timer_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop       = !empty && i_ready;
  assign push      = push_req && (!full || pop);
  assign overrun_d = push_req && full && !pop;

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      frame_err_q <= ferr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_valid     = !empty;
  assign o_data      = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1667, i_clk cycles per bit period (16 MHz / 9600 baud); legal range 8..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries; power of two, 2..16.
REQ-003 SHALL have port i_clk  input  1  system clock; the only clock.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_rx_unsafe  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port o_data  output  8  byte at FIFO head.
REQ-007 SHALL have port o_valid  output  1  FIFO non-empty; o_data is valid.
REQ-008 SHALL have port i_ready  input  1  consumer accepts the head byte.
REQ-009 SHALL have port o_frame_err  output  1  one-cycle pulse when a stop bit samples 0.
REQ-010 SHALL have port o_overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-011 SHALL pass i_rx_unsafe through a 2-flop synchronizer; all logic uses only the synchronized value (rx_s).
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, RECOVER with one shared bit-timer counter and a 3-bit bit index.
REQ-013 IDLE: rx_s==0 -> START with timer cleared; otherwise remain.
REQ-014 START: after CLKS_PER_BIT/2 cycles (integer division), sample rx_s; 0 -> DATA with timer cleared; 1 -> IDLE (glitch rejected, nothing reported).
REQ-015 DATA: every CLKS_PER_BIT cycles sample rx_s into the shift register LSB first; after the 8th sample -> STOP.
REQ-016 STOP: after CLKS_PER_BIT cycles sample rx_s; 1 -> push byte and go to IDLE; 0 -> pulse o_frame_err, discard byte, go to RECOVER.
REQ-017 RECOVER: remain until rx_s==1, then -> IDLE; a held-low line (break) produces exactly one o_frame_err.
REQ-018 FIFO SHALL be first-word-fall-through: o_data = head entry whenever o_valid=1; o_data is don't-care when o_valid=0.
REQ-019 Pop SHALL occur on a cycle where o_valid && i_ready; i_ready while empty SHALL have no effect.
REQ-020 Push SHALL take effect on the cycle after the stop-bit sample; o_valid rises that same cycle if the FIFO was empty.
REQ-021 Push when full with no simultaneous pop: byte dropped, FIFO unchanged, o_overrun pulses for one cycle.
REQ-022 Push and pop in the same cycle when full: both take effect, occupancy unchanged, no o_overrun.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy is tracked with one extra pointer bit or a count, never wrapping past FIFO_DEPTH.
REQ-024 Pushes SHALL be delivered in arrival order with no duplication or loss, except for drops under REQ-021.

Reset
REQ-025 While i_rst_n=0: FSM=IDLE, timer/index/shift register=0, synchronizer flops=1, FIFO empty, o_valid=0, o_frame_err=0, o_overrun=0, o_data=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame, lose buffered bytes, and emit no pulse.
REQ-027 After reset release, the first frame SHALL be accepted only from a falling edge seen in IDLE; a line already low at release enters START and resolves by REQ-014.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-028 Send 0xA5 (8N1, 16 clk/bit), i_ready=1 -> o_valid=1 with o_data=0xA5 for exactly one cycle; no error pulses.
REQ-029 Low glitch of 4 cycles on an idle line -> FSM returns to IDLE, o_valid stays 0, no pulses.
REQ-030 Send 0x3C with stop bit forced 0, then line high -> one o_frame_err pulse, FIFO stays empty; a following 0x81 is received correctly.
REQ-031 i_ready=0; send 0x01..0x05 -> 4 entries held, one o_overrun after byte 5; then i_ready=1 drains 0x01,0x02,0x03,0x04 in order.
REQ-032 FIFO full, i_ready pulsed high on the push cycle of a 5th byte 0x55 -> no o_overrun; drain yields 0x02,0x03,0x04,0x55.
REQ-033 Assert i_rst_n=0 during DATA bit 4 of a frame with 2 bytes buffered -> o_valid=0 immediately; after release a clean 0x7E is received alone.
